alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 145 ++++++++++++++
 tb/tb_alu_issue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: two-stage RV32I OP/OP-IMM issue pipeline.
// S1 decodes an accepted instruction into op/rv1/rv2 for an external
// combinational ALU; S2 captures that ALU's result (rvout) and presents it
// on the res_* interface. Illegal instructions travel the same path as
// zeroed bubbles flagged by res_illegal, so results retire in order.
//
// Handshake rule (both in_* and res_* sides): a transfer happens on a rising
// clk edge where valid and ready are both high; a producer holding valid
// keeps its payload stable until that edge; ready may depend combinationally
// on the consumer side (in_ready follows res_ready in the same cycle).
module alu_issue (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic [5:0]  op,
   output logic [31:0] rv1,
   output logic [31:0] rv2,
   input  logic [31:0] rvout,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [4:0]  res_rd,
   output logic        res_illegal,
   output logic [15:0] retired
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [5:0]  dec_op;
   logic [31:0] dec_rv1;
   logic [31:0] dec_rv2;
   logic        dec_illegal;

   logic        s1_valid;
   logic [4:0]  s1_rd;
   logic        s1_illegal;
   logic        s2_valid;

   logic        accept;
   logic        consume;
   logic        s2_load;

   // Register-index fields are resolved by whoever supplies rs1_val/rs2_val.
   logic        unused_rs_fields;
   assign unused_rs_fields = ^instr[19:15];

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign res_valid = s2_valid;
   assign consume   = s2_valid & res_ready;
   assign s2_load   = s1_valid & (~s2_valid | res_ready);
   assign in_ready  = ~s1_valid | s2_load;
   assign accept    = in_valid & in_ready;

   // Decode: op = {0, alt, r_type, funct3}; illegal words decode to all-zero.
   always_comb begin
      dec_illegal = 1'b1;
      dec_op      = 6'b000000;
      dec_rv1     = 32'h0;
      dec_rv2     = 32'h0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               dec_illegal = 1'b0;
               dec_op      = {1'b0, instr[30], 1'b1, funct3};
               dec_rv1     = rs1_val;
               dec_rv2     = rs2_val;
            end
         end
         OPC_OP_IMM: begin
            dec_illegal = 1'b0;
            if (funct3 == 3'b001 && funct7 != F7_BASE)
               dec_illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
               dec_illegal = 1'b1;
            if (!dec_illegal) begin
               dec_op  = {1'b0, (funct3 == 3'b101) ? instr[30] : 1'b0, 1'b0, funct3};
               dec_rv1 = rs1_val;
               dec_rv2 = {{20{instr[31]}}, instr[31:20]};
            end
         end
         default: ;
      endcase
   end

   // S1: load on accept, otherwise empty out when S2 takes the entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid   <= 1'b0;
         op         <= 6'b000000;
         rv1        <= 32'h0;
         rv2        <= 32'h0;
         s1_rd      <= 5'd0;
         s1_illegal <= 1'b0;
      end else if (accept) begin
         s1_valid   <= 1'b1;
         op         <= dec_op;
         rv1        <= dec_rv1;
         rv2        <= dec_rv2;
         s1_rd      <= instr[11:7];
         s1_illegal <= dec_illegal;
      end else if (s2_load) begin
         s1_valid   <= 1'b0;
      end
   end

   // S2: capture the ALU result for the S1 entry, or drain on consume.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid    <= 1'b0;
         res_data    <= 32'h0;
         res_rd      <= 5'd0;
         res_illegal <= 1'b0;
      end else if (s2_load) begin
         s2_valid    <= 1'b1;
         res_data    <= s1_illegal ? 32'h0 : rvout;
         res_rd      <= s1_rd;
         res_illegal <= s1_illegal;
      end else if (consume) begin
         s2_valid    <= 1'b0;
      end
   end

   // Retired-result counter, free-running wrap at 16 bits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         retired <= 16'h0000;
      else if (consume)
         retired <= retired + 16'h0001;
   end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of the alu_issue pipeline with a behavioural
// ALU closing the op/rv1/rv2 -> rvout loop.
module tb_alu_issue;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [5:0]  op;
   logic [31:0] rv1;
   logic [31:0] rv2;
   logic [31:0] rvout;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        res_illegal;
   logic [15:0] retired;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_retired;

   alu_issue dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .op(op), .rv1(rv1), .rv2(rv2), .rvout(rvout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_rd(res_rd), .res_illegal(res_illegal), .retired(retired)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural RV32I ALU
   always_comb begin
      rvout = 32'h0;
      case (op[2:0])
         3'b000: rvout = op[4] ? rv1 - rv2 : rv1 + rv2;
         3'b001: rvout = rv1 << rv2[4:0];
         3'b010: rvout = {31'h0, $signed(rv1) < $signed(rv2)};
         3'b011: rvout = {31'h0, rv1 < rv2};
         3'b100: rvout = rv1 ^ rv2;
         3'b101: rvout = op[4] ? $unsigned($signed(rv1) >>> rv2[4:0]) : rv1 >> rv2[4:0];
         3'b110: rvout = rv1 | rv2;
         default: rvout = rv1 & rv2;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one instruction into an empty pipeline with res_ready high
   task automatic run_one(input string tag, input logic [31:0] i_w, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] e_op,
                          input logic [31:0] e_rv2, input logic [31:0] e_data,
                          input logic [4:0] e_rd, input logic e_ill);
      instr = i_w; rs1_val = a; rs2_val = b; in_valid = 1'b1; res_ready = 1'b1;
      tick();
      check({tag, ".op"}, {26'h0, op}, {26'h0, e_op});
      check({tag, ".rv1"}, rv1, e_ill ? 32'h0 : a);
      check({tag, ".rv2"}, rv2, e_rv2);
      in_valid = 1'b0;
      tick();
      check({tag, ".res_valid"}, {31'h0, res_valid}, 32'h1);
      check({tag, ".res_data"}, res_data, e_data);
      check({tag, ".res_rd"}, {27'h0, res_rd}, {27'h0, e_rd});
      check({tag, ".res_illegal"}, {31'h0, res_illegal}, {31'h0, e_ill});
      tick();
      exp_retired = exp_retired + 16'h1;
      check({tag, ".retired"}, {16'h0, retired}, {16'h0, exp_retired});
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b0; instr = 32'h0;
      rs1_val = 32'h0; rs2_val = 32'h0; res_ready = 1'b0;
      exp_retired = 16'h0;
      tick(); tick();

      // reset state
      check("rst.res_valid", {31'h0, res_valid}, 32'h0);
      check("rst.in_ready", {31'h0, in_ready}, 32'h1);
      check("rst.op", {26'h0, op}, 32'h0);
      check("rst.rv1", rv1, 32'h0);
      check("rst.rv2", rv2, 32'h0);
      check("rst.res_data", res_data, 32'h0);
      check("rst.res_rd", {27'h0, res_rd}, 32'h0);
      check("rst.res_illegal", {31'h0, res_illegal}, 32'h0);
      check("rst.retired", {16'h0, retired}, 32'h0);
      resetn = 1'b1;
      tick();

      // addi x5,x0,-1
      instr = 32'hFFF00293; rs1_val = 32'h0; rs2_val = 32'h12345678;
      in_valid = 1'b1; res_ready = 1'b1;
      check("addi.in_ready", {31'h0, in_ready}, 32'h1);
      tick();
      check("addi.op", {26'h0, op}, 32'h0);
      check("addi.rv2", rv2, 32'hFFFFFFFF);
      check("addi.res_valid_early", {31'h0, res_valid}, 32'h0);
      in_valid = 1'b0;
      tick();
      check("addi.res_valid", {31'h0, res_valid}, 32'h1);
      check("addi.res_data", res_data, 32'hFFFFFFFF);
      check("addi.res_rd", {27'h0, res_rd}, 32'd5);
      check("addi.retired0", {16'h0, retired}, 32'd0);
      tick();
      check("addi.res_valid_done", {31'h0, res_valid}, 32'h0);
      check("addi.retired", {16'h0, retired}, 32'd1);

      // sub then srai back to back
      instr = 32'h402081B3; rs1_val = 32'd10; rs2_val = 32'd3; in_valid = 1'b1;
      tick();
      check("sub.op", {26'h0, op}, {26'h0, 6'b011000});
      check("sub.rv1", rv1, 32'd10);
      check("sub.rv2", rv2, 32'd3);
      check("sub.in_ready", {31'h0, in_ready}, 32'h1);
      instr = 32'h4040D213; rs1_val = 32'h80000000; rs2_val = 32'h55;
      tick();
      check("srai.op", {26'h0, op}, {26'h0, 6'b010101});
      check("srai.rv1", rv1, 32'h80000000);
      check("srai.rv2", rv2, 32'h00000404);
      check("sub.res_data", res_data, 32'd7);
      check("sub.res_rd", {27'h0, res_rd}, 32'd3);
      check("srai.in_ready", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      tick();
      check("srai.res_data", res_data, 32'hF8000000);
      check("srai.res_rd", {27'h0, res_rd}, 32'd4);
      tick();
      check("b2b.retired", {16'h0, retired}, 32'd3);

      // backpressure: three adds with res_ready low
      res_ready = 1'b0;
      instr = 32'h00208333; rs1_val = 32'd1; rs2_val = 32'd2; in_valid = 1'b1;
      tick();
      check("bp.in_ready1", {31'h0, in_ready}, 32'h1);
      check("bp.op", {26'h0, op}, {26'h0, 6'b001000});
      rs1_val = 32'd10; rs2_val = 32'd20;
      tick();
      check("bp.in_ready_full", {31'h0, in_ready}, 32'h0);
      check("bp.res_data1", res_data, 32'd3);
      rs1_val = 32'd100; rs2_val = 32'd200;
      tick();
      check("bp.hold_data", res_data, 32'd3);
      check("bp.hold_rd", {27'h0, res_rd}, 32'd6);
      check("bp.hold_rv1", rv1, 32'd10);
      check("bp.hold_rv2", rv2, 32'd20);
      check("bp.hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp.hold_retired", {16'h0, retired}, 32'd3);
      res_ready = 1'b1;
      #1;
      check("bp.in_ready_comb", {31'h0, in_ready}, 32'h1);
      tick();
      check("bp.res_data2", res_data, 32'd30);
      check("bp.rv1_3", rv1, 32'd100);
      check("bp.retired4", {16'h0, retired}, 32'd4);
      in_valid = 1'b0;
      tick();
      check("bp.res_data3", res_data, 32'd300);
      tick();
      check("bp.drained", {31'h0, res_valid}, 32'h0);
      check("bp.retired6", {16'h0, retired}, 32'd6);
      exp_retired = 16'd6;

      // legality and decode table
      run_one("jal",      32'h0000006F, 32'h1234, 32'h5678, 6'b000000, 32'h0, 32'h0, 5'd0, 1'b1);
      run_one("slli_bad", 32'h40309393, 32'd5, 32'd9, 6'b000000, 32'h0, 32'h0, 5'd7, 1'b1);
      run_one("slli",     32'h00309393, 32'd5, 32'd9, 6'b000001, 32'd3, 32'd40, 5'd7, 1'b0);
      run_one("mul",      32'h02208333, 32'd5, 32'd9, 6'b000000, 32'h0, 32'h0, 5'd6, 1'b1);
      run_one("sll_alt",  32'h40209333, 32'd5, 32'd9, 6'b000000, 32'h0, 32'h0, 5'd6, 1'b1);
      run_one("sra",      32'h4020D333, 32'hF0000000, 32'h24, 6'b011101, 32'h24, 32'hFF000000, 5'd6, 1'b0);
      run_one("srxi_bad", 32'h0240D213, 32'd5, 32'd9, 6'b000000, 32'h0, 32'h0, 5'd4, 1'b1);
      run_one("ori",      32'hFF00E113, 32'h0000000F, 32'd9, 6'b000110, 32'hFFFFFFF0, 32'hFFFFFFFF, 5'd2, 1'b0);

      // reset with both stages full
      res_ready = 1'b0; instr = 32'h00208333; rs1_val = 32'd1; rs2_val = 32'd1; in_valid = 1'b1;
      tick(); tick();
      check("mrst.full", {31'h0, in_ready}, 32'h0);
      in_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      check("mrst.res_valid", {31'h0, res_valid}, 32'h0);
      check("mrst.retired", {16'h0, retired}, 32'h0);
      check("mrst.in_ready", {31'h0, in_ready}, 32'h1);
      check("mrst.op", {26'h0, op}, 32'h0);
      check("mrst.res_data", res_data, 32'h0);
      tick();
      resetn = 1'b1;
      exp_retired = 16'h0;
      tick();
      run_one("post_rst", 32'h00500093, 32'h0, 32'h0, 6'b000000, 32'd5, 32'd5, 5'd1, 1'b0);

      // full-rate stream up to the retired wrap
      instr = 32'h00208333; in_valid = 1'b1; res_ready = 1'b1;
      for (int k = 1; k <= 65537; k++) begin
         rs1_val = k;
         rs2_val = 3 * k;
         tick();
         if (k >= 2 && (k % 4096 == 0 || k >= 65530)) begin
            check("stream.res_data", res_data, 4 * (k - 1));
            check("stream.in_ready", {31'h0, in_ready}, 32'h1);
            check("stream.res_valid", {31'h0, res_valid}, 32'h1);
         end
         if (k == 65536) check("wrap.ffff", {16'h0, retired}, 32'h0000FFFF);
         if (k == 65537) check("wrap.zero", {16'h0, retired}, 32'h0);
      end
      in_valid = 1'b0;
      tick(); tick();
      check("stream.drained", {31'h0, res_valid}, 32'h0);
      check("stream.retired", {16'h0, retired}, 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
